// File: rtl/disparity_match_core.sv
// Streaming SAD/SSD block-matching cost engine: accumulates per-candidate cost
// over template/candidate pixel pairs and emits the argmin disparity per job.
module disparity_match_core #(
   parameter int PIX_W      = 8,
   parameter int HALF_BLOCK = 3,
   parameter int MAX_DISP   = 64,
   parameter int DISP_W     = $clog2(MAX_DISP),
   parameter int COST_W     = 2*PIX_W + $clog2((2*HALF_BLOCK+1)*(2*HALF_BLOCK+1))
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [PIX_W-1:0]  in_tpl,
   input  logic [PIX_W-1:0]  in_cand,
   input  logic [DISP_W:0]   in_ncand,
   input  logic              cfg_mode,
   input  logic [COST_W-1:0] cfg_max_cost,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DISP_W-1:0] out_disp,
   output logic [COST_W-1:0] out_cost,
   output logic              out_invalid,
   output logic              busy
);
   localparam int BLOCK_SIZE = 2*HALF_BLOCK + 1;
   localparam int N          = BLOCK_SIZE*BLOCK_SIZE;
   localparam int BEAT_W     = (N > 1) ? $clog2(N) : 1;
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(N-1);
   localparam logic [DISP_W:0]   MAX_NCAND = (DISP_W+1)'(MAX_DISP);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ACCUM = 2'd1;
   localparam logic [1:0] S_EMIT  = 2'd2;

   logic [1:0]        state_q, state_d;
   logic              rdy_q, rdy_d;
   logic              mode_q, mode_d;
   logic [DISP_W:0]   ncand_q, ncand_d;
   logic [COST_W-1:0] thr_q, thr_d;
   logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;
   logic [DISP_W-1:0] cand_cnt_q, cand_cnt_d;
   logic [COST_W-1:0] acc_q, acc_d;
   logic [COST_W-1:0] best_cost_q, best_cost_d;
   logic [DISP_W-1:0] best_disp_q, best_disp_d;
   logic              invalid_q, invalid_d;

   logic              accept;
   logic              in_idle;
   logic [DISP_W:0]   ncand_in, ncand_eff;
   logic              mode_eff;
   logic [COST_W-1:0] thr_eff;
   logic [PIX_W-1:0]  abs_diff;
   logic [2*PIX_W-1:0] sq_diff;
   logic [COST_W-1:0] term, cand_cost, new_best;
   logic              last_beat, last_cand, take_best;

   assign in_ready    = rdy_q && (state_q != S_EMIT);
   assign accept      = in_valid && in_ready;
   assign out_valid   = (state_q == S_EMIT);
   assign busy        = (state_q != S_IDLE);
   assign out_disp    = best_disp_q;
   assign out_cost    = best_cost_q;
   assign out_invalid = invalid_q;

   always_comb begin
      in_idle = (state_q == S_IDLE);
      if (in_ncand == '0)
         ncand_in = (DISP_W+1)'(1);
      else if (in_ncand > MAX_NCAND)
         ncand_in = MAX_NCAND;
      else
         ncand_in = in_ncand;
      // The first beat is processed in IDLE, before the job config is latched.
      ncand_eff = in_idle ? ncand_in : ncand_q;
      mode_eff  = in_idle ? cfg_mode : mode_q;
      thr_eff   = in_idle ? cfg_max_cost : thr_q;

      abs_diff  = (in_tpl >= in_cand) ? (in_tpl - in_cand) : (in_cand - in_tpl);
      sq_diff   = {{PIX_W{1'b0}}, abs_diff} * {{PIX_W{1'b0}}, abs_diff};
      term      = mode_eff ? COST_W'(sq_diff) : COST_W'(abs_diff);
      cand_cost = acc_q + term;

      last_beat = (beat_cnt_q == LAST_BEAT);
      last_cand = ({1'b0, cand_cnt_q} == (ncand_eff - (DISP_W+1)'(1)));
      take_best = (cand_cnt_q == '0) || (cand_cost < best_cost_q);
      new_best  = take_best ? cand_cost : best_cost_q;

      state_d     = state_q;
      rdy_d       = 1'b1;
      mode_d      = mode_q;
      ncand_d     = ncand_q;
      thr_d       = thr_q;
      beat_cnt_d  = beat_cnt_q;
      cand_cnt_d  = cand_cnt_q;
      acc_d       = acc_q;
      best_cost_d = best_cost_q;
      best_disp_d = best_disp_q;
      invalid_d   = invalid_q;

      case (state_q)
         S_IDLE, S_ACCUM: begin
            if (accept) begin
               if (in_idle) begin
                  mode_d  = cfg_mode;
                  ncand_d = ncand_in;
                  thr_d   = cfg_max_cost;
                  state_d = S_ACCUM;
               end
               if (last_beat) begin
                  acc_d      = '0;
                  beat_cnt_d = '0;
                  if (take_best) begin
                     best_cost_d = cand_cost;
                     best_disp_d = cand_cnt_q;
                  end
                  if (last_cand) begin
                     cand_cnt_d = '0;
                     invalid_d  = (new_best > thr_eff);
                     state_d    = S_EMIT;
                  end else begin
                     cand_cnt_d = cand_cnt_q + DISP_W'(1);
                  end
               end else begin
                  acc_d      = cand_cost;
                  beat_cnt_d = beat_cnt_q + BEAT_W'(1);
               end
            end
         end
         S_EMIT: begin
            if (out_ready)
               state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         rdy_q       <= 1'b0;
         mode_q      <= 1'b0;
         ncand_q     <= '0;
         thr_q       <= '0;
         beat_cnt_q  <= '0;
         cand_cnt_q  <= '0;
         acc_q       <= '0;
         best_cost_q <= '0;
         best_disp_q <= '0;
         invalid_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         rdy_q       <= rdy_d;
         mode_q      <= mode_d;
         ncand_q     <= ncand_d;
         thr_q       <= thr_d;
         beat_cnt_q  <= beat_cnt_d;
         cand_cnt_q  <= cand_cnt_d;
         acc_q       <= acc_d;
         best_cost_q <= best_cost_d;
         best_disp_q <= best_disp_d;
         invalid_q   <= invalid_d;
      end
   end

endmodule

// File: tb/tb_disparity_match_core.sv
// Directed scoreboard bench for disparity_match_core: jobs push expected results,
// a negedge monitor pops and compares on every output handshake.
module tb_disparity_match_core;
   logic        clk;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  in_tpl;
   logic [7:0]  in_cand;
   logic [6:0]  in_ncand;
   logic        cfg_mode;
   logic [21:0] cfg_max_cost;
   logic        out_valid;
   logic        out_ready;
   logic [5:0]  out_disp;
   logic [21:0] out_cost;
   logic        out_invalid;
   logic        busy;

   disparity_match_core dut (
      .clk          (clk),
      .reset        (reset),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_tpl       (in_tpl),
      .in_cand      (in_cand),
      .in_ncand     (in_ncand),
      .cfg_mode     (cfg_mode),
      .cfg_max_cost (cfg_max_cost),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_disp     (out_disp),
      .out_cost     (out_cost),
      .out_invalid  (out_invalid),
      .busy         (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [5:0]  disp;
      logic [21:0] cost;
      logic        inv;
   } exp_t;

   exp_t       exp_q[$];
   int         n_vec = 0;
   int         n_err = 0;
   logic [7:0] tpl_arr[64];
   logic [7:0] cand_arr[64];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, req);
      end
   endtask

   task automatic push_exp(input int disp, input int cost, input bit inv);
      exp_t e;
      e.disp = 6'(disp);
      e.cost = 22'(cost);
      e.inv  = inv;
      exp_q.push_back(e);
   endtask

   // Monitor: compares on each handshake and checks outputs hold while stalled.
   logic        hold_vld = 1'b0;
   logic [5:0]  h_disp;
   logic [21:0] h_cost;
   logic        h_inv;
   always @(negedge clk) begin
      exp_t e;
      if (!reset && out_valid) begin
         check("emit_in_ready_low", in_ready, 0);
         if (hold_vld) begin
            check("stall_disp_stable", out_disp, h_disp);
            check("stall_cost_stable", out_cost, h_cost);
            check("stall_inv_stable", out_invalid, h_inv);
         end
         if (out_ready) begin
            hold_vld = 1'b0;
            if (exp_q.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL unexpected_output: got disp %0d cost %0d with empty scoreboard", out_disp, out_cost);
            end else begin
               e = exp_q.pop_front();
               check("out_disp", out_disp, e.disp);
               check("out_cost", out_cost, e.cost);
               check("out_invalid", out_invalid, e.inv);
               $display("result: disp %0d cost %0d invalid %0d", out_disp, out_cost, out_invalid);
            end
         end else begin
            hold_vld = 1'b1;
            h_disp   = out_disp;
            h_cost   = out_cost;
            h_inv    = out_invalid;
         end
      end else begin
         hold_vld = 1'b0;
      end
   end

   // Runs one job; abort_d/abort_b >= 0 asserts reset before that beat instead.
   task automatic run_job(input logic [6:0] nc_in, input int nc_eff, input logic mode,
                          input logic [21:0] thr, input bit ramp, input bit gaps,
                          input int abort_d, input int abort_b);
      int guard;
      for (int d = 0; d < nc_eff; d++) begin
         for (int b = 0; b < 49; b++) begin
            if (d == abort_d && b == abort_b) begin
               in_valid = 1'b0;
               #2;
               reset = 1'b1;
               #1;
               check("abort_out_valid", out_valid, 0);
               check("abort_out_disp", out_disp, 0);
               check("abort_out_cost", out_cost, 0);
               check("abort_out_invalid", out_invalid, 0);
               check("abort_busy", busy, 0);
               check("abort_in_ready", in_ready, 0);
               @(posedge clk); #1;
               reset = 1'b0;
               @(posedge clk); #1;
               check("abort_ready_back", in_ready, 1);
               return;
            end
            if (gaps && $urandom_range(0, 3) == 0) begin
               in_valid = 1'b0;
               in_tpl   = 8'($urandom);
               in_cand  = 8'($urandom);
               repeat ($urandom_range(1, 3)) @(posedge clk);
               #1;
            end
            in_valid = 1'b1;
            in_tpl   = ramp ? 8'(b) : tpl_arr[d];
            in_cand  = cand_arr[d];
            if (d == 0 && b == 0) begin
               in_ncand     = nc_in;
               cfg_mode     = mode;
               cfg_max_cost = thr;
            end else begin
               in_ncand     = 7'($urandom);
               cfg_mode     = ~mode;
               cfg_max_cost = '0;
            end
            guard = 0;
            while (!in_ready && guard < 100) begin
               @(posedge clk); #1;
               guard++;
            end
            if (!in_ready) begin
               n_vec++;
               n_err++;
               $display("FAIL beat_timeout: in_ready 0 at cand %0d beat %0d, required 1", d, b);
               in_valid = 1'b0;
               return;
            end
            @(posedge clk); #1;
            if (d == 0 && b == 0 && nc_eff * 49 > 1)
               check("busy_in_job", busy, 1);
         end
      end
      in_valid = 1'b0;
      check("latency_out_valid", out_valid, 1);
      check("emit_busy", busy, 1);
   endtask

   task automatic turnaround();
      @(posedge clk); #1;
      check("turn_in_ready", in_ready, 1);
      check("turn_out_valid", out_valid, 0);
      check("turn_busy", busy, 0);
   endtask

   initial begin
      reset        = 1'b1;
      in_valid     = 1'b0;
      in_tpl       = '0;
      in_cand      = '0;
      in_ncand     = '0;
      cfg_mode     = 1'b0;
      cfg_max_cost = '0;
      out_ready    = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_in_ready", in_ready, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_disp", out_disp, 0);
      check("rst_out_cost", out_cost, 0);
      check("rst_out_invalid", out_invalid, 0);
      check("rst_busy", busy, 0);
      reset = 1'b0;
      #1;
      check("release_in_ready_low", in_ready, 0);
      @(posedge clk); #1;
      check("release_in_ready_high", in_ready, 1);

      // SAD, costs 1470/980/490/0 -> disp 3
      for (int d = 0; d < 64; d++) begin tpl_arr[d] = 8'd100; cand_arr[d] = 8'(100 + 10*(3-d)); end
      push_exp(3, 0, 0);
      run_job(7'd4, 4, 1'b0, 22'd1000, 0, 0, -1, -1);
      turnaround();

      // Tie at 490, threshold equal -> valid
      cand_arr[0] = 8'd110; cand_arr[1] = 8'd90; cand_arr[2] = 8'd110;
      push_exp(0, 490, 0);
      run_job(7'd3, 3, 1'b0, 22'd490, 0, 0, -1, -1);
      turnaround();

      // SSD 441 vs 196, threshold 100 -> invalid
      tpl_arr[0] = 8'd50; cand_arr[0] = 8'd53; tpl_arr[1] = 8'd50; cand_arr[1] = 8'd48;
      push_exp(1, 196, 1);
      run_job(7'd2, 2, 1'b1, 22'd100, 0, 0, -1, -1);
      turnaround();

      // SSD 784/441/49/196 -> disp 2
      for (int d = 0; d < 4; d++) tpl_arr[d] = 8'd10;
      cand_arr[0] = 8'd14; cand_arr[1] = 8'd13; cand_arr[2] = 8'd11; cand_arr[3] = 8'd12;
      push_exp(2, 49, 1);
      run_job(7'd4, 4, 1'b1, 22'd0, 0, 0, -1, -1);
      turnaround();

      // SSD worst case 65025*49
      tpl_arr[0] = 8'd255; cand_arr[0] = 8'd0;
      push_exp(0, 3186225, 0);
      run_job(7'd1, 1, 1'b1, 22'd3186225, 0, 0, -1, -1);
      turnaround();

      // in_ncand=0 acts as one candidate
      tpl_arr[0] = 8'd50; cand_arr[0] = 8'd60;
      push_exp(0, 490, 1);
      run_job(7'd0, 1, 1'b0, 22'd489, 0, 0, -1, -1);
      turnaround();

      // Ramp template: SAD 600/1176/796 -> disp 0
      cand_arr[0] = 8'd24; cand_arr[1] = 8'd0; cand_arr[2] = 8'd10;
      push_exp(0, 600, 1);
      run_job(7'd3, 3, 1'b0, 22'd599, 1, 0, -1, -1);
      turnaround();

      // Gapped input and 20-cycle output stall, same result as gap-free SSD job
      tpl_arr[0] = 8'd50; cand_arr[0] = 8'd53; tpl_arr[1] = 8'd50; cand_arr[1] = 8'd48;
      out_ready = 1'b0;
      push_exp(1, 196, 1);
      run_job(7'd2, 2, 1'b1, 22'd100, 0, 1, -1, -1);
      repeat (20) begin
         @(posedge clk); #1;
         check("stall_in_ready", in_ready, 0);
         check("stall_out_valid", out_valid, 1);
      end
      out_ready = 1'b1;
      turnaround();

      // Reset at candidate 2 beat 17, then a clean full job
      for (int d = 0; d < 4; d++) begin tpl_arr[d] = 8'd100; cand_arr[d] = 8'(100 + 10*(3-d)); end
      run_job(7'd4, 4, 1'b0, 22'd1000, 0, 0, 2, 17);
      push_exp(3, 0, 0);
      run_job(7'd4, 4, 1'b0, 22'd1000, 0, 0, -1, -1);
      turnaround();

      // in_ncand=MAX_DISP+5 clamps to 64 candidates; min at index 63
      for (int d = 0; d < 64; d++) begin tpl_arr[d] = 8'd100; cand_arr[d] = 8'(101 + (63-d)); end
      push_exp(63, 49, 0);
      run_job(7'd69, 64, 1'b0, 22'd49, 0, 0, -1, -1);
      turnaround();

      repeat (5) @(posedge clk);
      #1;
      check("scoreboard_drained", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      n_err++;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/disparity_match_core.md
# disparity_match_core

Parametrised, streaming block-matching cost engine for the Nexys3 disparity pipeline. It replaces the fixed 7×7, 50-candidate SAD/argmin logic with a reusable core. An upstream block fetcher streams template/candidate pixel pairs under valid/ready. The core accumulates SAD or SSD cost per candidate and tracks the running minimum. For each output pixel it emits one disparity index, that index's cost and a validity flag to the resultant-image writer.

## Interface

Parameters:
- PIX_W, 8, pixel width in bits.
- HALF_BLOCK, 3, half block size; BLOCK_SIZE = 2*HALF_BLOCK+1; N = BLOCK_SIZE².
- MAX_DISP, 64, maximum candidates per job.
- DISP_W, $clog2(MAX_DISP), disparity index width.
- COST_W, 2*PIX_W+$clog2(N), cost width; holds the worst-case SSD.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- in_valid  in  1  beat valid
- in_ready  out  1  core accepts beat
- in_tpl  in  PIX_W  template pixel
- in_cand  in  PIX_W  candidate-block pixel
- in_ncand  in  DISP_W+1  candidate count for job; sampled on first beat
- cfg_mode  in  1  0 = SAD, 1 = SSD; sampled on first beat
- cfg_max_cost  in  COST_W  invalidation threshold; sampled on first beat
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_disp  out  DISP_W  argmin candidate index
- out_cost  out  COST_W  minimum cost
- out_invalid  out  1  min cost > cfg_max_cost
- busy  out  1  job in progress (state ≠ IDLE)

## Operation

- A job is in_ncand candidates × N beats, candidate-major. Within a candidate, beats are in block raster order; candidate d uses disparity index d, from 0 upward.
- A beat is accepted when in_valid && in_ready.
- Effective ncand = in_ncand clamped to [1, MAX_DISP]: 0 → 1, >MAX_DISP → MAX_DISP.
- Term per beat: SAD = |tpl−cand|, zero-extended to COST_W; SSD = (tpl−cand)², unsigned. All arithmetic is unsigned and non-saturating; COST_W guarantees no overflow.
- Counters: beat_cnt 0..N−1 and cand_cnt 0..ncand−1. Both wrap to 0 at job end.
- State machine:
  - IDLE: in_ready=1. The first accepted beat latches ncand, mode and threshold, then goes to ACCUM. That beat is also accumulated.
  - ACCUM: in_ready=1.
    - On every accepted beat: acc ← acc + term. On the last beat of a candidate, acc is instead cleared.
    - Candidate cost = acc + term. It is compared combinationally in that beat's cycle.
    - Update (best_cost, best_disp) when cand_cnt==0 or cost < best_cost. The comparison is strict, so ties keep the lower index.
    - Last beat of the last candidate → EMIT.
  - EMIT: in_ready=0, out_valid=1.
    - out_disp, out_cost and out_invalid stay stable until out_ready.
    - On the handshake → IDLE, and out_valid drops the next cycle.
    - A new job's first beat can be accepted one cycle after the handshake.
- out_invalid = (best_cost > cfg_max_cost). This is registered on entry to EMIT.
- A single-beat job (N=1, ncand=1) goes IDLE → EMIT directly.
- in_valid low mid-job stalls the counters and accumulator; nothing is lost.
- Reset mid-operation clears every register and counter asynchronously. Any partial job is discarded with no output.

## Timing

- Reset values: in_ready 0 while reset is asserted, 1 from the first clock edge after release. out_valid 0, out_disp 0, out_cost 0, out_invalid 0, busy 0. The state is IDLE.
- Throughput: 1 beat/cycle in ACCUM.
- Latency: out_valid asserts on the cycle after the final beat is accepted.
- Job turnaround overhead is 1 cycle (EMIT with immediate out_ready) plus 0 IDLE bubbles.
- Per job: ncand·N + 1 cycles at full rate with out_ready held high.
- cfg_* and in_ncand are ignored after the first beat; mid-job changes have no effect.
- in_tpl, in_cand and in_ncand are don't-care when in_valid=0.

## Test plan

- Defaults; SAD; ncand=4. Candidate d has all tpl=100 and cand=100+10·(3−d) → out_disp=3, out_cost=0, out_invalid=0 one cycle after beat 196.
- Tie: ncand=3 with equal costs of 490 (|diff|=10 for every beat) → out_disp=0, out_cost=490.
- SSD mode: ncand=2. Candidate 0 diff=3 → 9·49=441; candidate 1 diff=2 → 196 → out_disp=1, out_cost=196. With cfg_max_cost=100, out_invalid=1.
- Overflow corner: SSD, tpl=255, cand=0 on all 49 beats, ncand=1 → out_cost=3186225 with no wrap. in_ncand=0 behaves as 1 and in_ncand=MAX_DISP+5 behaves as MAX_DISP.
- Backpressure and stall: random in_valid gaps plus out_ready held low 20 cycles. in_ready=0 throughout EMIT, outputs stay stable, and the result is identical to the gap-free run. The next job's first beat is accepted the cycle after the out handshake.
- Async reset asserted mid-ACCUM (candidate 2, beat 17) → all outputs are 0 immediately. A full job then starts cleanly and produces the correct result.
